clock_gate_ctrl: RTL and testbench

//  Generates the glitch-free enable that drives the downstream AND-type clock gate (clk_out = clk_in & enable).

---
 rtl/clock_gate_ctrl_if.sv | 20 ++
 rtl/clock_gate_ctrl.sv | 98 +++++++++
 tb/tb_clock_gate_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/clock_gate_ctrl_if.sv
// rtl/clock_gate_ctrl_if.sv - activity/override inputs and gate outputs of the clock gate controller
interface clock_gate_ctrl_if;
  logic busy;
  logic wake_req;
  logic force_on;
  logic sleep_allow;
  logic gate_en;
  logic gated;
  logic wake_ack;

  modport master (
    output busy, wake_req, force_on, sleep_allow,
    input  gate_en, gated, wake_ack
  );

  modport slave (
    input  busy, wake_req, force_on, sleep_allow,
    output gate_en, gated, wake_ack
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - idle-timed clock gate enable with negedge-retimed, glitch-free output
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  clock_gate_ctrl_if.slave cg
);
  localparam int MAX_C = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] IDLE_N = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_N = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {S_RUN, S_IDLE, S_GATED, S_WAKE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, gated_q, wake_ack_q, wake_ack_d, gate_en_q;
  logic             stay_on;

  assign stay_on = cg.busy | cg.wake_req | cg.force_on | ~cg.sleep_allow;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_ack_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!stay_on) begin
          state_d = S_IDLE;
          cnt_d   = ONE;
        end
      end
      S_IDLE: begin
        // Activity on the completing edge still wins, so the window restarts.
        if (stay_on) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_N) begin
          state_d = S_GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_GATED: begin
        if (stay_on) begin
          state_d = S_WAKE;
          cnt_d   = ONE;
        end
      end
      S_WAKE: begin
        if (cnt_q == WAKE_N) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          wake_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      en_q       <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= (state_d != S_GATED);
      gated_q    <= (state_d == S_GATED);
      wake_ack_q <= wake_ack_d;
    end
  end

  // Falling-edge retime keeps gate_en stable for the whole high phase of clk_in.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_en_q <= 1'b1;
    end else begin
      gate_en_q <= en_q;
    end
  end

  assign cg.gate_en  = gate_en_q;
  assign cg.gated    = gated_q;
  assign cg.wake_ack = wake_ack_q;
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - directed and random checks of clock_gate_ctrl against an idle-run model
module tb_clock_gate_ctrl;
  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic clk_out;
  clock_gate_ctrl_if cg_if ();

  clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .cg     (cg_if)
  );

  always #5 clk_in = ~clk_in;
  assign clk_out = clk_in & cg_if.gate_en;

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  mon_on = 1'b0;
  time t_rise = 0;

  // Reference model: length of the current idle run, sleeping flag, wake progress.
  int idle_run;
  bit sleeping;
  bit waking;
  int wake_el;
  bit ack_exp;
  bit en_prev;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(cg_if.gate_en) if (mon_on) chk("gate_en_change_in_low_phase", clk_in, 1'b0);
  always @(posedge clk_out) if (mon_on) begin
    t_rise = $time;
    chk("clk_out_rise_on_clk_edge", (($time % 10) == 5), 1'b1);
  end
  always @(negedge clk_out) if (mon_on) chk("clk_out_full_high_phase", (($time - t_rise) == 5), 1'b1);

  task automatic model_reset();
    idle_run = 0;
    sleeping = 1'b0;
    waking   = 1'b0;
    wake_el  = 0;
    ack_exp  = 1'b0;
    en_prev  = 1'b1;
  endtask

  task automatic step(input bit b, input bit w, input bit f, input bit a);
    bit stay;
    cg_if.busy        = b;
    cg_if.wake_req    = w;
    cg_if.force_on    = f;
    cg_if.sleep_allow = a;
    stay = b | w | f | ~a;
    @(posedge clk_in);
    ack_exp = 1'b0;
    if (waking) begin
      wake_el++;
      if (wake_el == WAKE) begin
        waking   = 1'b0;
        ack_exp  = 1'b1;
        idle_run = 0;
      end
    end else if (sleeping) begin
      if (stay) begin
        sleeping = 1'b0;
        waking   = 1'b1;
        wake_el  = 0;
      end
    end else if (stay) begin
      idle_run = 0;
    end else begin
      idle_run++;
      if (idle_run == IDLE + 1) begin
        sleeping = 1'b1;
        idle_run = 0;
      end
    end
    #1;
    chk("gated", cg_if.gated, sleeping);
    chk("wake_ack", cg_if.wake_ack, ack_exp);
    chk("gate_en_held_high_phase", cg_if.gate_en, en_prev);
    @(negedge clk_in);
    #1;
    chk("gate_en_after_negedge", cg_if.gate_en, ~sleeping);
    en_prev = ~sleeping;
  endtask

  task automatic async_reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_gate_en", cg_if.gate_en, 1'b1);
    chk("async_rst_gated", cg_if.gated, 1'b0);
    chk("async_rst_wake_ack", cg_if.wake_ack, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    cg_if.busy        = 1'b0;
    cg_if.wake_req    = 1'b0;
    cg_if.force_on    = 1'b0;
    cg_if.sleep_allow = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    chk("reset_gate_en", cg_if.gate_en, 1'b1);
    chk("reset_gated", cg_if.gated, 1'b0);
    chk("reset_wake_ack", cg_if.wake_ack, 1'b0);
    rst_n = 1'b1;
    model_reset();
    mon_on = 1'b1;

    // Idle from reset: gating after the full idle window.
    repeat (IDLE) step(0, 0, 0, 1);
    chk("t1_not_gated_yet", cg_if.gated, 1'b0);
    step(0, 0, 0, 1);
    chk("t1_gated", cg_if.gated, 1'b1);
    chk("t1_gate_en_low", cg_if.gate_en, 1'b0);

    // One-cycle wake pulse, then ack after the wake window.
    step(0, 1, 0, 1);
    chk("t3_gate_en_restored", cg_if.gate_en, 1'b1);
    step(0, 0, 0, 1);
    chk("t3_no_ack_early", cg_if.wake_ack, 1'b0);
    step(0, 0, 0, 1);
    chk("t3_ack", cg_if.wake_ack, 1'b1);
    step(0, 0, 0, 1);
    chk("t3_ack_one_cycle", cg_if.wake_ack, 1'b0);

    // Busy pulse late in the window restarts it.
    repeat (IDLE - 2) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (IDLE) step(0, 0, 0, 1);
    chk("t2_restarted_not_gated", cg_if.gated, 1'b0);
    step(0, 0, 0, 1);
    chk("t2_gated", cg_if.gated, 1'b1);

    // Overrides: raising force_on while gated wakes; held overrides never gate.
    step(0, 0, 1, 1);
    chk("t4_force_wakes", cg_if.gate_en, 1'b1);
    repeat (100) step(0, 0, 1, 1);
    chk("t4_force_held", cg_if.gate_en, 1'b1);
    repeat (100) step(0, 0, 0, 0);
    chk("t4_no_allow_held", cg_if.gate_en, 1'b1);

    // Async reset mid-GATED and mid-WAKE.
    repeat (IDLE + 1) step(0, 0, 0, 1);
    chk("t6_in_gated", cg_if.gated, 1'b1);
    async_reset_pulse();
    repeat (IDLE + 1) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    async_reset_pulse();
    repeat (4) step(0, 0, 0, 1);

    // Random activity against the model with the glitch monitors active.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
